// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : SPI mode-0 master, one 8-bit full-duplex transfer per start,
//            SCLK derived from clk by a programmable half-period divider.
// Revision : 1.0 - initial release
// ============================================================================

module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] masterDataToSend,
  output logic [7:0] masterDataReceived,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       CS,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int                 c_CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_div_cnt;
  logic [6:0]         r_tx;       // bits still to send after the one on MOSI
  logic [7:0]         r_rx;
  logic [3:0]         r_bit_cnt;
  logic               w_div_last;

  assign w_div_last = (r_div_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_div_cnt          <= '0;
      r_tx               <= '0;
      r_rx               <= '0;
      r_bit_cnt          <= '0;
      masterDataReceived <= 8'h00;
      busy               <= 1'b0;
      done               <= 1'b0;
      SCLK               <= 1'b0;
      CS                 <= 1'b1;
      MOSI               <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_div_cnt <= '0;
          SCLK      <= 1'b0;
          if (start) begin
            r_tx      <= masterDataToSend[6:0];
            r_rx      <= 8'h00;
            r_bit_cnt <= 4'd0;
            MOSI      <= masterDataToSend[7];
            CS        <= 1'b0;
            busy      <= 1'b1;
            r_state   <= S_SETUP;
          end else begin
            MOSI    <= 1'b0;
            CS      <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_SETUP: begin
          if (w_div_last) begin
            r_div_cnt <= '0;
            SCLK      <= 1'b1;
            r_rx      <= {r_rx[6:0], MISO};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_state   <= S_HIGH;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_HIGH: begin
          if (w_div_last) begin
            r_div_cnt <= '0;
            SCLK      <= 1'b0;
            r_tx      <= {r_tx[5:0], 1'b0};
            MOSI      <= (r_bit_cnt < 4'd8) ? r_tx[6] : 1'b0;
            r_state   <= S_LOW;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_LOW: begin
          if (w_div_last) begin
            r_div_cnt <= '0;
            if (r_bit_cnt < 4'd8) begin
              SCLK      <= 1'b1;
              r_rx      <= {r_rx[6:0], MISO};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_state   <= S_HIGH;
            end else begin
              r_state <= S_HOLD;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (w_div_last) begin
            r_div_cnt          <= '0;
            CS                 <= 1'b1;
            busy               <= 1'b0;
            done               <= 1'b1;
            MOSI               <= 1'b0;
            masterDataReceived <= r_rx;
            r_state            <= S_DONE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        default: begin
          r_div_cnt <= '0;
          SCLK      <= 1'b0;
          CS        <= 1'b1;
          MOSI      <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Scoreboard bench for spi_master (CLK_DIV=4 and CLK_DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy, done, SCLK, CS, MOSI, MISO;

  logic       start1;
  logic [7:0] tx_data1, rx_data1;
  logic       busy1, done1, SCLK1, CS1, MOSI1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [1:0] mode = 2'd0;  // 0 loopback, 1 MISO tied high, 2 slave model

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .masterDataToSend(tx_data),
    .masterDataReceived(rx_data), .busy(busy), .done(done),
    .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .masterDataToSend(tx_data1),
    .masterDataReceived(rx_data1), .busy(busy1), .done(done1),
    .SCLK(SCLK1), .CS(CS1), .MOSI(MOSI1), .MISO(MOSI1)
  );

  // Mode-0 slave: presents bit 7 when CS falls, advances on each SCLK fall.
  logic [7:0] slv_tx = 8'h3C;
  logic [7:0] slv_rx = 8'h00;
  int         slv_cnt = 0;
  logic       slave_bit;

  always @(negedge SCLK or posedge CS) begin
    if (CS) slv_cnt = 0;
    else    slv_cnt = slv_cnt + 1;
  end
  always @(posedge SCLK) slv_rx = {slv_rx[6:0], MOSI};
  assign slave_bit = (slv_cnt < 8) ? slv_tx[3'(7 - slv_cnt)] : 1'b0;

  assign MISO = (mode == 2'd0) ? MOSI : (mode == 2'd1) ? 1'b1 : slave_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         cycle;
    bit         mosi_zero;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: pops one expectation per done pulse and checks per-transfer framing.
  int   cs_low_cnt = 0;
  int   rise_cnt   = 0;
  int   done_cnt   = 0;
  bit   mosi_one   = 0;
  logic sclk_prev  = 1'b0;
  logic mosi_prev  = 1'b0;
  logic rst_prev   = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      cs_low_cnt = 0;
      rise_cnt   = 0;
      mosi_one   = 0;
    end else begin
      if (!CS) cs_low_cnt++;
      if (MOSI) mosi_one = 1;
      if (!rst_prev && (SCLK != sclk_prev))
        check("sclk_edge_with_cs_low", 32'(CS), 32'd0);
      if (SCLK && !sclk_prev) begin
        rise_cnt++;
        check("mosi_stable_at_rise", 32'(MOSI), 32'(mosi_prev));
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("done_cycle", cyc, e.cycle);
          check("cs_low_cycles", cs_low_cnt, 32'd72);
          check("sclk_rises", rise_cnt, 32'd8);
          if (e.mosi_zero) check("mosi_all_zero", 32'(mosi_one), 32'd0);
        end
        cs_low_cnt = 0;
        rise_cnt   = 0;
        mosi_one   = 0;
      end
    end
    sclk_prev = SCLK;
    mosi_prev = MOSI;
    rst_prev  = reset;
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [7:0] d, input logic [1:0] m, input logic [7:0] exp_rx,
                       input bit mz, output int t0);
    mode = m;
    @(posedge clk); #1;
    start   = 1'b1;
    tx_data = d;
    t0      = cyc;
    exp_q.push_back('{exp_rx, t0 + 73, mz});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    if (exp_q.size() != 0) begin
      check("scoreboard_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int snap;
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    tx_data  = 8'h00;
    start1   = 1'b0;
    tx_data1 = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_cs",   32'(CS),      32'd1);
    check("reset_sclk", 32'(SCLK),    32'd0);
    check("reset_mosi", 32'(MOSI),    32'd0);
    check("reset_busy", 32'(busy),    32'd0);
    check("reset_done", 32'(done),    32'd0);
    check("reset_rx",   32'(rx_data), 32'd0);

    // Loopback A5
    issue(8'hA5, 2'd0, 8'hA5, 1'b0, t0);
    @(negedge clk);
    check("busy_first_cycle", 32'(busy), 32'd1);
    check("cs_first_cycle",   32'(CS),   32'd0);
    check("mosi_first_bit",   32'(MOSI), 32'd1);
    drain(100);

    // MISO tied high, send 00
    issue(8'h00, 2'd1, 8'hFF, 1'b1, t0);
    drain(100);

    // Slave returns 3C while master sends C3
    issue(8'hC3, 2'd2, 8'h3C, 1'b0, t0);
    drain(100);
    check("slave_received", 32'(slv_rx), 32'hC3);

    // Second start and data change mid-transfer are ignored
    issue(8'hA5, 2'd0, 8'hA5, 1'b0, t0);
    goto(t0 + 10);
    start   = 1'b1;
    tx_data = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    snap  = done_cnt;
    drain(100);
    repeat (80) @(posedge clk);
    #1;
    check("single_done_after_restart", done_cnt - snap, 32'd1);

    // start held high: back-to-back transfers
    mode = 2'd0;
    @(posedge clk); #1;
    start   = 1'b1;
    tx_data = 8'h81;
    t0      = cyc;
    exp_q.push_back('{8'h81, t0 + 73, 1'b0});
    exp_q.push_back('{8'h81, t0 + 146, 1'b0});
    goto(t0 + 73);
    @(negedge clk);
    check("b2b_gap_cs_high", 32'(CS), 32'd1);
    goto(t0 + 74);
    @(negedge clk);
    check("b2b_second_cs_low", 32'(CS), 32'd0);
    goto(t0 + 80);
    start = 1'b0;
    drain(200);

    // Reset mid-transfer
    @(posedge clk); #1;
    start   = 1'b1;
    tx_data = 8'hF0;
    t0      = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    snap  = done_cnt;
    goto(t0 + 30);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_cs",   32'(CS),      32'd1);
    check("abort_sclk", 32'(SCLK),    32'd0);
    check("abort_mosi", 32'(MOSI),    32'd0);
    check("abort_busy", 32'(busy),    32'd0);
    check("abort_rx",   32'(rx_data), 32'd0);
    repeat (90) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - snap, 32'd0);

    // CLK_DIV=1 loopback
    start1   = 1'b1;
    tx_data1 = 8'h96;
    t0       = cyc;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done1 && n < 40) begin
      @(negedge clk); n++;
    end
    check("div1_done_seen",  32'(done1),    32'd1);
    check("div1_done_cycle", cyc,           t0 + 19);
    check("div1_rx",         32'(rx_data1), 32'h96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
